// File: rtl/ooo_pkg.sv
// Shared definitions for the out-of-order core: tag and data widths,
// the reorder buffer entry layout, and the result-bus FSM states.
package ooo_pkg;

  localparam int TAG_W     = 3;
  localparam int DATA_W    = 32;
  localparam int ROB_DEPTH = 8;
  localparam int COUNT_W   = TAG_W + 1;

  typedef struct packed {
    logic              valid;
    logic              done;
    logic              bcast;
    logic              exc;
    logic [TAG_W-1:0]  dest;
    logic [DATA_W-1:0] value;
  } rob_entry_t;

  typedef enum logic {
    IDLE  = 1'b0,
    PULSE = 1'b1
  } bus_state_t;

endpackage

// File: rtl/reorder_buffer.sv
// Eight-entry circular reorder buffer: two-wide allocate, tag-addressed completion,
// one-at-a-time result broadcast, in-order commit and exception flush.
module reorder_buffer
  import ooo_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               alloc_one,
  input  logic               alloc_two,
  input  logic [TAG_W-1:0]   alloc_a_dest,
  input  logic [TAG_W-1:0]   alloc_b_dest,
  output logic [TAG_W-1:0]   alloc_a_tag,
  output logic [TAG_W-1:0]   alloc_b_tag,
  output logic [COUNT_W-1:0] free_slots,
  input  logic               add_done,
  input  logic               mul_done,
  input  logic [TAG_W-1:0]   add_tag,
  input  logic [TAG_W-1:0]   mul_tag,
  input  logic [DATA_W-1:0]  add_value,
  input  logic [DATA_W-1:0]  mul_value,
  input  logic               add_exc,
  input  logic               mul_exc,
  output logic               ROB_bus_trigger,
  output logic               ROB_exception_flush,
  output logic [TAG_W-1:0]   ROB_bus_tag,
  output logic [DATA_W-1:0]  ROB_bus_value,
  output logic               commit_valid,
  output logic [TAG_W-1:0]   commit_dest,
  output logic [DATA_W-1:0]  commit_value
);

  rob_entry_t           entries [ROB_DEPTH];
  logic [TAG_W-1:0]     head;
  logic [TAG_W-1:0]     tail;
  logic [COUNT_W-1:0]   count;
  bus_state_t           state;
  bus_state_t           state_next;

  logic [ROB_DEPTH-1:0] bcast_ready;
  rob_entry_t           head_entry;
  logic                 do_flush;
  logic                 do_commit;
  logic                 do_bcast;
  logic                 sel_found;
  logic [TAG_W-1:0]     sel_idx;
  logic                 add_hit;
  logic                 mul_hit;
  logic [1:0]           n_alloc;

  // Oldest ready entry in program order: the lowest distance from head wins.
  function automatic logic [TAG_W:0] oldest_ready(input logic [ROB_DEPTH-1:0] ready,
                                                  input logic [TAG_W-1:0]     start);
    logic [TAG_W:0]   result;
    logic [TAG_W-1:0] idx;
    result = '0;
    for (int i = ROB_DEPTH - 1; i >= 0; i--) begin
      idx = start + TAG_W'(i);
      if (ready[idx]) result = {1'b1, idx};
    end
    return result;
  endfunction

  assign alloc_a_tag = tail;
  assign alloc_b_tag = tail + TAG_W'(1);
  assign free_slots  = COUNT_W'(ROB_DEPTH) - count;
  assign head_entry  = entries[head];

  always_comb begin
    bcast_ready = '0;
    for (int i = 0; i < ROB_DEPTH; i++) begin
      bcast_ready[i] = entries[i].valid & entries[i].done & ~entries[i].bcast & ~entries[i].exc;
    end
  end

  always_comb begin
    do_flush  = (state == IDLE) && head_entry.valid && head_entry.done && head_entry.exc;
    do_commit = head_entry.valid && head_entry.done && head_entry.bcast && !head_entry.exc;
    {sel_found, sel_idx} = oldest_ready(bcast_ready, head);
    do_bcast  = (state == IDLE) && !do_flush && sel_found;

    // A request that does not fit is dropped whole; alloc_two shadows alloc_one.
    n_alloc = 2'd0;
    if (alloc_two) begin
      n_alloc = (free_slots >= COUNT_W'(2)) ? 2'd2 : 2'd0;
    end else if (alloc_one) begin
      n_alloc = (free_slots != '0) ? 2'd1 : 2'd0;
    end

    add_hit = add_done && entries[add_tag].valid && !entries[add_tag].done;
    mul_hit = mul_done && !(add_done && (add_tag == mul_tag)) &&
              entries[mul_tag].valid && !entries[mul_tag].done;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (do_flush || do_bcast) state_next = PULSE;
      PULSE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ROB_DEPTH; i++) entries[i] <= '0;
      head                <= '0;
      tail                <= '0;
      count               <= '0;
      ROB_bus_trigger     <= 1'b0;
      ROB_exception_flush <= 1'b0;
      ROB_bus_tag         <= '0;
      ROB_bus_value       <= '0;
      commit_valid        <= 1'b0;
      commit_dest         <= '0;
      commit_value        <= '0;
    end else begin
      ROB_bus_trigger     <= 1'b0;
      ROB_exception_flush <= 1'b0;
      commit_valid        <= 1'b0;

      if (add_hit) begin
        entries[add_tag].done  <= 1'b1;
        entries[add_tag].value <= add_value;
        entries[add_tag].exc   <= add_exc;
      end
      if (mul_hit) begin
        entries[mul_tag].done  <= 1'b1;
        entries[mul_tag].value <= mul_value;
        entries[mul_tag].exc   <= mul_exc;
      end

      if (do_bcast) begin
        ROB_bus_trigger        <= 1'b1;
        ROB_bus_tag            <= sel_idx;
        ROB_bus_value          <= entries[sel_idx].value;
        entries[sel_idx].bcast <= 1'b1;
      end

      if (do_commit) begin
        commit_valid  <= 1'b1;
        commit_dest   <= head_entry.dest;
        commit_value  <= head_entry.value;
        entries[head] <= '0;
      end

      if (n_alloc != 2'd0) begin
        entries[tail] <= '{valid: 1'b1, done: 1'b0, bcast: 1'b0, exc: 1'b0,
                           dest: alloc_a_dest, value: '0};
      end
      if (n_alloc == 2'd2) begin
        entries[tail + TAG_W'(1)] <= '{valid: 1'b1, done: 1'b0, bcast: 1'b0, exc: 1'b0,
                                       dest: alloc_b_dest, value: '0};
      end

      head  <= head + TAG_W'(do_commit);
      tail  <= tail + TAG_W'(n_alloc);
      count <= count + COUNT_W'(n_alloc) - COUNT_W'(do_commit);

      // The excepting instruction and everything younger are discarded; this
      // overrides every other update made above in the same cycle.
      if (do_flush) begin
        for (int i = 0; i < ROB_DEPTH; i++) entries[i] <= '0;
        head                <= head + TAG_W'(1);
        tail                <= head + TAG_W'(1);
        count               <= '0;
        ROB_bus_trigger     <= 1'b1;
        ROB_exception_flush <= 1'b1;
        ROB_bus_tag         <= head;
        ROB_bus_value       <= '0;
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: a program-order queue model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_reorder_buffer;
  import ooo_pkg::*;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              alloc_one = 1'b0;
  logic              alloc_two = 1'b0;
  logic [2:0]        alloc_a_dest = '0;
  logic [2:0]        alloc_b_dest = '0;
  logic [2:0]        alloc_a_tag;
  logic [2:0]        alloc_b_tag;
  logic [3:0]        free_slots;
  logic              add_done = 1'b0;
  logic              mul_done = 1'b0;
  logic [2:0]        add_tag = '0;
  logic [2:0]        mul_tag = '0;
  logic [31:0]       add_value = '0;
  logic [31:0]       mul_value = '0;
  logic              add_exc = 1'b0;
  logic              mul_exc = 1'b0;
  logic              ROB_bus_trigger;
  logic              ROB_exception_flush;
  logic [2:0]        ROB_bus_tag;
  logic [31:0]       ROB_bus_value;
  logic              commit_valid;
  logic [2:0]        commit_dest;
  logic [31:0]       commit_value;

  reorder_buffer dut (
    .clk(clk), .reset(reset),
    .alloc_one(alloc_one), .alloc_two(alloc_two),
    .alloc_a_dest(alloc_a_dest), .alloc_b_dest(alloc_b_dest),
    .alloc_a_tag(alloc_a_tag), .alloc_b_tag(alloc_b_tag), .free_slots(free_slots),
    .add_done(add_done), .mul_done(mul_done), .add_tag(add_tag), .mul_tag(mul_tag),
    .add_value(add_value), .mul_value(mul_value), .add_exc(add_exc), .mul_exc(mul_exc),
    .ROB_bus_trigger(ROB_bus_trigger), .ROB_exception_flush(ROB_exception_flush),
    .ROB_bus_tag(ROB_bus_tag), .ROB_bus_value(ROB_bus_value),
    .commit_valid(commit_valid), .commit_dest(commit_dest), .commit_value(commit_value)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Model: entries kept oldest-first in a queue; head tag tracked separately.
  typedef struct {
    logic [2:0]  tag;
    logic [2:0]  dest;
    bit          done;
    bit          exc;
    bit          bcast;
    logic [31:0] value;
  } model_entry_t;

  model_entry_t mq[$];
  logic [2:0]   m_head = '0;
  bit           m_pulse = 1'b0;
  logic         e_trig = 1'b0;
  logic         e_flush = 1'b0;
  logic [2:0]   e_btag = '0;
  logic [31:0]  e_bval = '0;
  logic         e_cv = 1'b0;
  logic [2:0]   e_cdest = '0;
  logic [31:0]  e_cval = '0;

  typedef struct packed { logic flush; logic [2:0] tag; logic [31:0] value; } bc_rec_t;
  typedef struct packed { logic [2:0] dest; logic [31:0] value; } cm_rec_t;
  bc_rec_t bc_log[$];
  cm_rec_t cm_log[$];

  task automatic model_post(input logic [2:0] tag, input logic [31:0] value, input logic exc);
    model_entry_t e;
    for (int i = 0; i < mq.size(); i++) begin
      if (mq[i].tag == tag && !mq[i].done) begin
        e = mq[i];
        e.done = 1'b1;
        e.value = value;
        e.exc = exc;
        mq[i] = e;
      end
    end
  endtask

  task automatic model_push(input logic [2:0] tag, input logic [2:0] dest);
    model_entry_t e;
    e.tag = tag; e.dest = dest; e.done = 1'b0; e.exc = 1'b0; e.bcast = 1'b0; e.value = '0;
    mq.push_back(e);
  endtask

  task automatic model_step();
    int n;
    int sel;
    bit flush;
    bit commit;
    logic [2:0] tail;
    model_entry_t e;
    n = mq.size();
    tail = m_head + 3'(n);
    flush = !m_pulse && n > 0 && mq[0].done && mq[0].exc;
    commit = n > 0 && mq[0].done && mq[0].bcast && !mq[0].exc;
    sel = -1;
    if (!m_pulse && !flush) begin
      for (int i = 0; i < n; i++) begin
        if (sel < 0 && mq[i].done && !mq[i].bcast && !mq[i].exc) sel = i;
      end
    end
    e_cv = commit;
    if (commit) begin
      e_cdest = mq[0].dest;
      e_cval = mq[0].value;
    end
    e_trig = 1'b0;
    e_flush = 1'b0;
    if (flush) begin
      e_trig = 1'b1; e_flush = 1'b1; e_btag = m_head; e_bval = '0;
    end else if (sel >= 0) begin
      e_trig = 1'b1; e_btag = mq[sel].tag; e_bval = mq[sel].value;
      e = mq[sel];
      e.bcast = 1'b1;
      mq[sel] = e;
    end
    m_pulse = e_trig;
    if (add_done) model_post(add_tag, add_value, add_exc);
    if (mul_done && !(add_done && add_tag == mul_tag)) model_post(mul_tag, mul_value, mul_exc);
    if (flush) begin
      mq.delete();
      m_head = m_head + 3'd1;
    end else begin
      if (commit) begin
        void'(mq.pop_front());
        m_head = m_head + 3'd1;
      end
      if (alloc_two) begin
        if (8 - n >= 2) begin
          model_push(tail, alloc_a_dest);
          model_push(tail + 3'd1, alloc_b_dest);
        end
      end else if (alloc_one && 8 - n >= 1) begin
        model_push(tail, alloc_a_dest);
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        mq.delete();
        m_head = '0; m_pulse = 1'b0;
        e_trig = 1'b0; e_flush = 1'b0; e_btag = '0; e_bval = '0;
        e_cv = 1'b0; e_cdest = '0; e_cval = '0;
      end else begin
        model_step();
      end
    end
  end

  // Compare process: every falling edge while out of reset.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        check_output("free_slots", free_slots, 32'(8 - mq.size()));
        check_output("alloc_a_tag", alloc_a_tag, 32'(3'(m_head + 3'(mq.size()))));
        check_output("alloc_b_tag", alloc_b_tag, 32'(3'(m_head + 3'(mq.size()) + 3'd1)));
        check_output("bus_trigger", ROB_bus_trigger, e_trig);
        check_output("bus_flush", ROB_exception_flush, e_flush);
        if (e_trig) begin
          check_output("bus_tag", ROB_bus_tag, e_btag);
          check_output("bus_value", ROB_bus_value, e_bval);
        end
        check_output("commit_valid", commit_valid, e_cv);
        if (e_cv) begin
          check_output("commit_dest", commit_dest, e_cdest);
          check_output("commit_value", commit_value, e_cval);
        end
        if (ROB_bus_trigger) bc_log.push_back({ROB_exception_flush, ROB_bus_tag, ROB_bus_value});
        if (commit_valid) cm_log.push_back({commit_dest, commit_value});
      end
    end
  end

  task automatic apply_stimulus(input logic two, input logic one,
                                input logic [2:0] da, input logic [2:0] db);
    alloc_two = two; alloc_one = one; alloc_a_dest = da; alloc_b_dest = db;
    @(negedge clk);
    alloc_two = 1'b0; alloc_one = 1'b0;
  endtask

  task automatic apply_complete(input logic is_add, input logic [2:0] tag,
                                input logic [31:0] value, input logic exc);
    if (is_add) begin
      add_done = 1'b1; add_tag = tag; add_value = value; add_exc = exc;
    end else begin
      mul_done = 1'b1; mul_tag = tag; mul_value = value; mul_exc = exc;
    end
    @(negedge clk);
    add_done = 1'b0; mul_done = 1'b0; add_exc = 1'b0; mul_exc = 1'b0;
  endtask

  task automatic pulse_reset();
    #1 reset = 1'b0;
    @(negedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_trigger(input int limit, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (ROB_bus_trigger) seen = 1'b1;
    end
  endtask

  task automatic wait_commit(input int limit, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (commit_valid) seen = 1'b1;
    end
  endtask

  initial begin
    bit seen;
    bit found0;
    bit found1;
    int bc_start;
    int cm_start;

    repeat (3) @(negedge clk);
    check_output("rst_trigger", ROB_bus_trigger, 0);
    check_output("rst_flush", ROB_exception_flush, 0);
    check_output("rst_bus_tag", ROB_bus_tag, 0);
    check_output("rst_bus_value", ROB_bus_value, 0);
    check_output("rst_commit_valid", commit_valid, 0);
    check_output("rst_commit_dest", commit_dest, 0);
    check_output("rst_commit_value", commit_value, 0);
    check_output("rst_free_slots", free_slots, 8);
    check_output("rst_alloc_a_tag", alloc_a_tag, 0);
    check_output("rst_alloc_b_tag", alloc_b_tag, 1);
    #1 reset = 1'b1;
    @(negedge clk);

    // Two-wide allocate, out-of-order completion, in-order commit.
    apply_stimulus(1'b1, 1'b0, 3'd1, 3'd2);
    check_output("alloc2_free", free_slots, 6);
    check_output("alloc2_next_tag", alloc_a_tag, 2);
    bc_start = bc_log.size();
    cm_start = cm_log.size();
    apply_complete(1'b0, 3'd1, 32'd42, 1'b0);
    apply_complete(1'b1, 3'd0, 32'd7, 1'b0);
    repeat (10) @(negedge clk);
    check_output("bcast_count", bc_log.size() - bc_start, 2);
    found0 = 1'b0;
    found1 = 1'b0;
    for (int i = bc_start; i < bc_log.size(); i++) begin
      if (bc_log[i] == {1'b0, 3'd0, 32'd7}) found0 = 1'b1;
      if (bc_log[i] == {1'b0, 3'd1, 32'd42}) found1 = 1'b1;
    end
    check_output("bcast_tag0_val7", found0, 1);
    check_output("bcast_tag1_val42", found1, 1);
    check_output("commit_count", cm_log.size() - cm_start, 2);
    if (cm_log.size() - cm_start == 2) begin
      check_output("commit0", cm_log[cm_start], {3'd1, 32'd7});
      check_output("commit1", cm_log[cm_start + 1], {3'd2, 32'd42});
    end
    check_output("drained_free", free_slots, 8);

    // Fill from a fresh state, reject an overflow, then wrap after one commit.
    pulse_reset();
    apply_stimulus(1'b1, 1'b0, 3'd3, 3'd4);
    apply_stimulus(1'b1, 1'b0, 3'd5, 3'd6);
    apply_stimulus(1'b1, 1'b0, 3'd7, 3'd0);
    apply_stimulus(1'b1, 1'b0, 3'd1, 3'd2);
    check_output("full_free", free_slots, 0);
    apply_stimulus(1'b0, 1'b1, 3'd5, 3'd0);
    check_output("overflow_free", free_slots, 0);
    check_output("overflow_tag", alloc_a_tag, 0);
    apply_complete(1'b1, 3'd0, 32'd100, 1'b0);
    wait_commit(10, seen);
    check_output("wrap_commit_seen", seen, 1);
    check_output("wrap_commit_dest", commit_dest, 3);
    check_output("wrap_commit_value", commit_value, 100);
    check_output("wrap_free", free_slots, 1);
    check_output("wrap_tag", alloc_a_tag, 0);
    apply_stimulus(1'b0, 1'b1, 3'd6, 3'd0);
    check_output("refill_free", free_slots, 0);

    // Adder and multiplier report the same tag: the adder result is kept.
    add_done = 1'b1; add_tag = 3'd3; add_value = 32'd5;
    mul_done = 1'b1; mul_tag = 3'd3; mul_value = 32'd9;
    @(negedge clk);
    add_done = 1'b0; mul_done = 1'b0;
    wait_trigger(10, seen);
    check_output("same_tag_seen", seen, 1);
    check_output("same_tag_tag", ROB_bus_tag, 3);
    check_output("same_tag_value", ROB_bus_value, 5);

    // Exception at head: flush pulse, everything discarded, nothing commits.
    pulse_reset();
    apply_stimulus(1'b1, 1'b0, 3'd1, 3'd2);
    apply_stimulus(1'b1, 1'b0, 3'd3, 3'd4);
    check_output("pre_flush_free", free_slots, 4);
    cm_start = cm_log.size();
    apply_complete(1'b1, 3'd0, 32'd77, 1'b1);
    wait_trigger(10, seen);
    check_output("flush_seen", seen, 1);
    check_output("flush_flag", ROB_exception_flush, 1);
    check_output("flush_tag", ROB_bus_tag, 0);
    check_output("flush_value", ROB_bus_value, 0);
    @(negedge clk);
    check_output("post_flush_free", free_slots, 8);
    check_output("post_flush_head", alloc_a_tag, 1);
    check_output("post_flush_trigger", ROB_bus_trigger, 0);
    repeat (3) @(negedge clk);
    check_output("flush_no_commit", cm_log.size() - cm_start, 0);

    // Reset asserted in the middle of a pulse clears outputs without a clock edge.
    apply_stimulus(1'b0, 1'b1, 3'd5, 3'd0);
    apply_complete(1'b1, 3'd1, 32'd55, 1'b0);
    wait_trigger(10, seen);
    check_output("pulse_seen", seen, 1);
    check_output("pulse_tag", ROB_bus_tag, 1);
    #1 reset = 1'b0;
    #1;
    check_output("async_trigger", ROB_bus_trigger, 0);
    check_output("async_free", free_slots, 8);
    check_output("async_tag", alloc_a_tag, 0);
    check_output("async_bus_tag", ROB_bus_tag, 0);
    @(negedge clk);
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
